mode_state_machine: RTL
=======================

// Module: mode_state_machine
// PURPOSE
//  Owns current_mode. Consumes single-cycle mode-toggle pulses from the per-mode controllers
//  (first/second/third_mode_toggle) and the menu standby request, and runs the timed modes:
//  second (fixed-length high-speed run), second-exit (delayed return to standby) and third
//  (self-clean). Drives current_mode back to every *_mode_controller_top and to the display.
// PARAMETERS
//  SECOND_SECONDS  60   second-mode run length; at 0 goes to FIRST_MODE (1..255)
//  EXIT_SECONDS    60   delay after menu press in second mode before STAND_MODE (1..255)
//  THIRD_SECONDS   180  third-mode run length; at 0 goes to STAND_MODE (1..255)
//  COUNT_WIDTH     8    width of seconds_left
// PORTS
//  clk                 in   1            system clock
//  rst                 in   1            synchronous reset, active-high
//  tick_1hz            in   1            one-cycle pulse per second
//  first_mode_toggle   in   1            one-cycle request: enter FIRST_MODE
//  second_mode_toggle  in   1            one-cycle request: enter SECOND_MODE
//  third_mode_toggle   in   1            one-cycle request: enter THIRD_MODE
//  standby_toggle      in   1            one-cycle menu request: leave to STAND_MODE
//  current_mode        out  MODE_WIDTH   `STAND_MODE/`FIRST_MODE/`SECOND_MODE/`THIRD_MODE
//  seconds_left        out  COUNT_WIDTH  remaining seconds of active timed phase, else 0
//  exit_pending        out  1            1 while second-mode exit countdown runs
//  second_used         out  1            second mode consumed since reset
//  mode_changed        out  1            one-cycle pulse on the cycle after current_mode changes
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): current_mode=`STAND_MODE, seconds_left=0, exit_pending=0,
//    second_used=0, mode_changed=0. Reset mid-countdown aborts immediately.
//  - All outputs registered; a toggle in cycle n changes current_mode at edge n+1,
//    mode_changed high in cycle n+1 only.
//  - Same-cycle requests: standby > third > second > first; one transition per cycle.
//  - Entry into a timed phase loads seconds_left from its parameter; a tick in the entry
//    cycle is ignored (load wins over decrement).
//  - STAND: first->FIRST; second->SECOND if allowed; third->THIRD; standby ignored.
//  - FIRST: second->SECOND if allowed; third->THIRD; standby->STAND; first ignored.
//  - SECOND (exit_pending=0): load SECOND_SECONDS, set second_used. Each tick decrements;
//    tick at seconds_left==1 -> FIRST, seconds_left=0. standby -> exit_pending=1, reload
//    EXIT_SECONDS, mode stays SECOND. first/second/third ignored.
//  - SECOND (exit_pending=1): tick decrements; tick at 1 -> STAND, exit_pending=0,
//    seconds_left=0. All toggles incl. repeat standby ignored.
//  - THIRD: load THIRD_SECONDS; tick at 1 -> STAND. second->SECOND if allowed; standby and
//    first ignored (self-clean is not interruptible by menu).
//  - seconds_left never underflows; stays 0 in untimed modes; no tick effect at 0.
//  - Illegal current_mode encoding: next edge forces STAND_MODE, counters cleared.
// CONFIGURATION
//  SECOND_MODE_ONCE_EN defined: second mode allowed only while second_used==0; once
//   entered, further second_mode_toggle is ignored until reset.
//  Not defined: second mode always allowed; second_used still sets on first entry but
//   never gates transitions.
// TESTING
//  1 Reset, first_mode_toggle -> current_mode=FIRST next edge, mode_changed 1 cycle, seconds_left=0.
//  2 FIRST, second_mode_toggle, 60 ticks -> SECOND with 60..1, on 60th tick FIRST, seconds_left=0.
//  3 SECOND at seconds_left=25, standby_toggle -> exit_pending=1, seconds_left=60; repeat standby
//    ignored; 60 ticks -> STAND, exit_pending=0.
//  4 STAND, third+first same cycle -> THIRD, seconds_left=180; 180 ticks -> STAND; standby ignored.
//  5 ONCE_EN defined: after a second-mode run, second_mode_toggle in FIRST -> stays FIRST;
//    undefined: re-enters SECOND, seconds_left=60.
//  6 rst mid-THIRD (seconds_left=90) -> STAND, seconds_left=0, second_used=0; tick+toggle same
//    cycle -> loaded value, no decrement.

Source files
------------

// File: rtl/mode_state_machine.sv
// Mode state machine: owns current_mode and runs the timed second, second-exit and third phases.
// Optional build macro SECOND_MODE_ONCE_EN limits second mode to one entry per reset.
`ifndef STAND_MODE
`define STAND_MODE 3'd0
`endif
`ifndef FIRST_MODE
`define FIRST_MODE 3'd1
`endif
`ifndef SECOND_MODE
`define SECOND_MODE 3'd2
`endif
`ifndef THIRD_MODE
`define THIRD_MODE 3'd3
`endif
`ifndef MODE_WIDTH
`define MODE_WIDTH 3
`endif

module mode_state_machine #(
  parameter int unsigned SECOND_SECONDS = 60,
  parameter int unsigned EXIT_SECONDS   = 60,
  parameter int unsigned THIRD_SECONDS  = 180,
  parameter int unsigned COUNT_WIDTH    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick_1hz,
  input  logic                   first_mode_toggle,
  input  logic                   second_mode_toggle,
  input  logic                   third_mode_toggle,
  input  logic                   standby_toggle,
  output logic [`MODE_WIDTH-1:0] current_mode,
  output logic [COUNT_WIDTH-1:0] seconds_left,
  output logic                   exit_pending,
  output logic                   second_used,
  output logic                   mode_changed
);

  localparam logic [COUNT_WIDTH-1:0] SECOND_LOAD = COUNT_WIDTH'(SECOND_SECONDS);
  localparam logic [COUNT_WIDTH-1:0] EXIT_LOAD   = COUNT_WIDTH'(EXIT_SECONDS);
  localparam logic [COUNT_WIDTH-1:0] THIRD_LOAD  = COUNT_WIDTH'(THIRD_SECONDS);
  localparam logic [COUNT_WIDTH-1:0] ONE         = COUNT_WIDTH'(1);

  typedef enum logic [`MODE_WIDTH-1:0] {
    ST_STAND  = `STAND_MODE,
    ST_FIRST  = `FIRST_MODE,
    ST_SECOND = `SECOND_MODE,
    ST_THIRD  = `THIRD_MODE
  } mode_e;

  mode_e                  mode_q, mode_d;
  logic [COUNT_WIDTH-1:0] secs_q, secs_d;
  logic                   exit_q, exit_d;
  logic                   used_q, used_d;
  logic                   changed_q, changed_d;
  logic                   second_ok;
  logic                   expire;
  logic                   dec;

`ifdef SECOND_MODE_ONCE_EN
  assign second_ok = ~used_q;
`else
  assign second_ok = 1'b1;
`endif

  assign expire = tick_1hz && (secs_q == ONE);
  assign dec    = tick_1hz && (secs_q != '0);

  // Next-state: highest-priority request that is legal in the current mode wins, else the timer runs
  always_comb begin
    mode_d = mode_q;
    secs_d = secs_q;
    exit_d = exit_q;
    used_d = used_q;
    case (mode_q)
      ST_STAND, ST_FIRST: begin
        secs_d = '0;
        exit_d = 1'b0;
        if (standby_toggle && mode_q == ST_FIRST) begin
          mode_d = ST_STAND;
        end else if (third_mode_toggle) begin
          mode_d = ST_THIRD;
          secs_d = THIRD_LOAD;
        end else if (second_mode_toggle && second_ok) begin
          mode_d = ST_SECOND;
          secs_d = SECOND_LOAD;
          used_d = 1'b1;
        end else if (first_mode_toggle && mode_q == ST_STAND) begin
          mode_d = ST_FIRST;
        end
      end
      ST_SECOND: begin
        if (standby_toggle && !exit_q) begin
          exit_d = 1'b1;
          secs_d = EXIT_LOAD;
        end else if (expire) begin
          mode_d = exit_q ? ST_STAND : ST_FIRST;
          exit_d = 1'b0;
          secs_d = '0;
        end else if (dec) begin
          secs_d = secs_q - ONE;
        end
      end
      ST_THIRD: begin
        exit_d = 1'b0;
        if (second_mode_toggle && second_ok) begin
          mode_d = ST_SECOND;
          secs_d = SECOND_LOAD;
          used_d = 1'b1;
        end else if (expire) begin
          mode_d = ST_STAND;
          secs_d = '0;
        end else if (dec) begin
          secs_d = secs_q - ONE;
        end
      end
      default: begin
        mode_d = ST_STAND;
        secs_d = '0;
        exit_d = 1'b0;
      end
    endcase
    changed_d = (mode_d != mode_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= ST_STAND;
      secs_q    <= '0;
      exit_q    <= 1'b0;
      used_q    <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      secs_q    <= secs_d;
      exit_q    <= exit_d;
      used_q    <= used_d;
      changed_q <= changed_d;
    end
  end

  assign current_mode = mode_q;
  assign seconds_left = secs_q;
  assign exit_pending = exit_q;
  assign second_used  = used_q;
  assign mode_changed = changed_q;

endmodule
